fft_oflow_monitor: RTL and testbench
====================================

Name: fft_oflow_monitor

Overview:
- Sits directly upstream of the FFT overflow software register. It watches the PFB/FFT overflow flag and frame sync in the DSP clock domain.
- Condenses them into one 32-bit status word that drives that register's user_data_in.
- The word reports sticky overflow, sticky sync-period error, a count of frames with overflow, and the peak per-frame overflow sample count. It is cleared by a software control bit.

Parameters:
- FRAME_LEN, 256: expected sync period in user_clk cycles. Must be ≥ 4.
- SYNC_CHECK, 1: 1 enables sync-period checking; 0 holds sync_err at 0.

Ports:
- user_clk  in  1  DSP clock. All logic runs on the rising edge.
- user_rst_n  in  1  asynchronous, active-low reset.
- sync_in  in  1  frame-start pulse from the FFT, one cycle wide.
- oflow_in  in  1  FFT overflow flag for the current sample, valid every cycle.
- clear_in  in  1  software clear level, synchronous to user_clk. Acts on its rising edge.
- user_data_out  out  32  status word, registered: [31] sticky oflow, [30] sticky sync_err, [29:16] frame_oflow_cnt, [15:0] peak_cnt.
- armed  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release): state IDLE; user_data_out = 0x00000000; armed = 0; all internal counters 0; clear edge detector primed to 0.
- Clear event: clear_in = 1 while the previous-cycle sample was 0.
  - Next edge: every status field zeroed, cur_cnt = 0, pos = 0, state IDLE.
  - Clear dominates every other event on the same cycle, including sync, oflow and frame close. A sync on the clear cycle is ignored.
  - A constant-high clear_in causes exactly one clear.
- IDLE:
  - oflow_in is ignored.
  - sync_in moves to RUN with pos = 0 and cur_cnt = oflow_in. The sync cycle is sample 0 of the frame.
- RUN:
  - Each cycle, pos increments and wraps from FRAME_LEN-1 to 0.
  - cur_cnt increments on oflow_in and saturates at 0xFFFF.
  - oflow_in = 1 sets sticky bit [31] on the next edge.
- Frame close happens on sync_in in RUN, and only on sync (a pos wrap without sync does not close the frame).
  - If cur_cnt > 0: frame_oflow_cnt += 1, saturating at 0x3FFF.
  - peak_cnt = max(peak_cnt, cur_cnt).
  - cur_cnt restarts at oflow_in of the sync cycle.
  - pos is forced to 0, which realigns the frame.
- Sync check (SYNC_CHECK = 1, RUN only): sync_err is set (sticky) in either case:
  - sync_in arrives while pos ≠ FRAME_LEN-1 (early sync);
  - pos == FRAME_LEN-1 and sync_in is absent on the following cycle (missing sync).
- Latency:
  - All fields are visible on user_data_out on the edge after the causing cycle; user_data_out is a registered copy.
  - Sticky bit: 1 cycle after oflow_in.
  - Frame count and peak: 1 cycle after the closing sync.
- Sticky bits clear only on clear or reset.
- Counters never wrap; they hold at their maximum value.
- armed = (state == RUN), registered.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is discarded.

Test Plan (FRAME_LEN = 16):
- Reset, then 40 cycles of oflow_in = 1 with no sync → user_data_out stays 0x00000000, armed = 0.
- Syncs every 16 cycles, with 3 oflow pulses in frame 1 and 5 in frame 2, then the 3rd sync → user_data_out = 0x80020005; armed = 1.
- Sync at pos 9 (early) → bit 30 set, frame realigned. A later sync 16 cycles after that raises no new error. Separately, an omitted sync sets bit 30 one cycle after the expected slot.
- Clear rising edge coincident with a sync and an oflow → next cycle user_data_out = 0, armed = 0. The following sync re-arms the block. Holding clear high causes no further clears.
- 20000 frames each containing an overflow → frame_oflow_cnt saturates at 0x3FFF. oflow_in held high across 70000 cycles with syncs suppressed, then one sync → peak_cnt = 0xFFFF.
- user_rst_n pulsed low mid-frame → user_data_out = 0 asynchronously. After release, behaviour is as from cold reset.

Source files
------------

// File: rtl/fft_oflow_monitor_if.sv
// Frame-sync/overflow inputs and status outputs of the FFT overflow monitor.
interface fft_oflow_monitor_if;
    logic        sync_in;
    logic        oflow_in;
    logic        clear_in;
    logic [31:0] user_data_out;
    logic        armed;

    modport master (
        output sync_in, oflow_in, clear_in,
        input  user_data_out, armed
    );

    modport slave (
        input  sync_in, oflow_in, clear_in,
        output user_data_out, armed
    );
endinterface

// File: rtl/fft_oflow_monitor.sv
// Condenses FFT overflow flag and frame sync into a 32-bit status word:
// sticky overflow, sticky sync error, overflowed-frame count, peak per-frame overflow count.
module fft_oflow_monitor #(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned SYNC_CHECK = 1
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    fft_oflow_monitor_if.slave   mon
);

    localparam int unsigned POS_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned CUR_W   = 16;
    localparam int unsigned FRAME_W = 14;
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [CUR_W-1:0]   CUR_MAX   = '1;
    localparam logic [FRAME_W-1:0] FRAME_MAX = '1;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [POS_W-1:0]   pos, pos_nxt;
    logic [CUR_W-1:0]   cur_cnt, cur_nxt;
    logic [FRAME_W-1:0] frame_cnt, frame_nxt;
    logic [CUR_W-1:0]   peak_cnt, peak_nxt;
    logic               sticky_oflow, sticky_oflow_nxt;
    logic               sync_err, sync_err_nxt;
    logic               clear_q;
    logic               clear_evt;
    logic               check_en;

    assign clear_evt = mon.clear_in & ~clear_q;
    assign check_en  = (SYNC_CHECK != 0);

    // State and status registers; user_data_out is a direct view of the status flops.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= IDLE;
            pos          <= '0;
            cur_cnt      <= '0;
            frame_cnt    <= '0;
            peak_cnt     <= '0;
            sticky_oflow <= 1'b0;
            sync_err     <= 1'b0;
            clear_q      <= 1'b0;
            mon.armed    <= 1'b0;
        end else begin
            state        <= state_nxt;
            pos          <= pos_nxt;
            cur_cnt      <= cur_nxt;
            frame_cnt    <= frame_nxt;
            peak_cnt     <= peak_nxt;
            sticky_oflow <= sticky_oflow_nxt;
            sync_err     <= sync_err_nxt;
            clear_q      <= mon.clear_in;
            mon.armed    <= (state_nxt == RUN);
        end
    end

    assign mon.user_data_out = {sticky_oflow, sync_err, frame_cnt, peak_cnt};

    // Next-state: clear wins over everything; frames close only on sync.
    always_comb begin
        state_nxt        = state;
        pos_nxt          = pos;
        cur_nxt          = cur_cnt;
        frame_nxt        = frame_cnt;
        peak_nxt         = peak_cnt;
        sticky_oflow_nxt = sticky_oflow;
        sync_err_nxt     = sync_err;

        if (clear_evt) begin
            state_nxt        = IDLE;
            pos_nxt          = '0;
            cur_nxt          = '0;
            frame_nxt        = '0;
            peak_nxt         = '0;
            sticky_oflow_nxt = 1'b0;
            sync_err_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mon.sync_in) begin
                        state_nxt = RUN;
                        pos_nxt   = '0;
                        cur_nxt   = CUR_W'(mon.oflow_in);
                    end
                end
                RUN: begin
                    if (mon.oflow_in) begin
                        sticky_oflow_nxt = 1'b1;
                    end
                    if (mon.sync_in) begin
                        if ((cur_cnt != '0) && (frame_cnt != FRAME_MAX)) begin
                            frame_nxt = frame_cnt + FRAME_W'(1);
                        end
                        if (cur_cnt > peak_cnt) begin
                            peak_nxt = cur_cnt;
                        end
                        cur_nxt = CUR_W'(mon.oflow_in);
                        pos_nxt = '0;
                        if (check_en && (pos != POS_LAST)) begin
                            sync_err_nxt = 1'b1;
                        end
                    end else begin
                        pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
                        if (mon.oflow_in && (cur_cnt != CUR_MAX)) begin
                            cur_nxt = cur_cnt + CUR_W'(1);
                        end
                        // The sync slot is the cycle where pos sits at the last sample.
                        if (check_en && (pos == POS_LAST)) begin
                            sync_err_nxt = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_oflow_monitor.sv
// Directed bench for fft_oflow_monitor with FRAME_LEN = 16 and hand-computed status words.
module tb_fft_oflow_monitor;

    logic user_clk = 1'b0;
    logic user_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fft_oflow_monitor_if bus();

    fft_oflow_monitor #(.FRAME_LEN(16), .SYNC_CHECK(1)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .mon        (bus)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; return 1 time unit after the edge that consumed them.
    task automatic cyc(input logic s, input logic o, input logic c);
        bus.sync_in  = s;
        bus.oflow_in = o;
        bus.clear_in = c;
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        bus.sync_in  = 1'b0;
        bus.oflow_in = 1'b0;
        bus.clear_in = 1'b0;

        // Cold reset, then overflow without sync must stay invisible.
        repeat (3) @(posedge user_clk);
        #1;
        check("reset_data", bus.user_data_out, 32'h0000_0000);
        check("reset_armed", 32'(bus.armed), 32'h0);
        user_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0);
        check("idle_oflow_data", bus.user_data_out, 32'h0000_0000);
        check("idle_oflow_armed", 32'(bus.armed), 32'h0);

        // Two regular frames: 3 then 5 overflows.
        cyc(1'b1, 1'b0, 1'b0);
        check("arm_data", bus.user_data_out, 32'h0000_0000);
        check("arm_armed", 32'(bus.armed), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        check("sticky_latency", bus.user_data_out, 32'h8000_0000);
        for (int i = 2; i <= 15; i++) cyc(1'b0, (i <= 3), 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("frame1_close", bus.user_data_out, 32'h8001_0003);
        for (int i = 1; i <= 15; i++) cyc(1'b0, (i <= 5), 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("frame2_close", bus.user_data_out, 32'h8002_0005);
        check("frame2_armed", 32'(bus.armed), 32'h1);

        // Early sync at pos 9, then an on-time sync 16 cycles later.
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
        check("pre_early", bus.user_data_out, 32'h8002_0005);
        cyc(1'b1, 1'b0, 1'b0);
        check("early_sync", bus.user_data_out, 32'hC002_0005);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("realigned_sync", bus.user_data_out, 32'hC002_0005);

        // Clear, re-arm, one good frame, then an omitted sync.
        cyc(1'b0, 1'b0, 1'b1);
        check("clear_data", bus.user_data_out, 32'h0000_0000);
        check("clear_armed", 32'(bus.armed), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("ontime_no_err", bus.user_data_out, 32'h0000_0000);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0);
        check("before_slot", bus.user_data_out, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b0);
        check("missing_sync", bus.user_data_out, 32'h4000_0000);

        // Clear edge together with sync and oflow; held clear must not re-clear.
        cyc(1'b0, 1'b1, 1'b0);
        check("pre_clear", bus.user_data_out, 32'hC000_0000);
        cyc(1'b1, 1'b1, 1'b1);
        check("clear_dominates", bus.user_data_out, 32'h0000_0000);
        check("clear_dom_armed", 32'(bus.armed), 32'h0);
        cyc(1'b0, 1'b1, 1'b1);
        check("held_clear_idle", bus.user_data_out, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b1);
        check("rearm_armed", 32'(bus.armed), 32'h1);
        cyc(1'b0, 1'b1, 1'b1);
        check("held_clear_oflow", bus.user_data_out, 32'h8000_0000);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("held_clear_keep", bus.user_data_out, 32'h8000_0000);

        // Asynchronous reset mid-frame.
        user_rst_n = 1'b0;
        #2;
        check("async_rst_data", bus.user_data_out, 32'h0000_0000);
        check("async_rst_armed", 32'(bus.armed), 32'h0);
        @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        check("post_rst_idle", bus.user_data_out, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0);
        check("post_rst_armed", 32'(bus.armed), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        check("post_rst_oflow", bus.user_data_out, 32'h8000_0000);

        // Frame-count saturation: sync every cycle, each 1-sample frame overflowed.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("sat_start", bus.user_data_out, 32'h0000_0000);
        for (int i = 0; i < 101; i++) cyc(1'b1, 1'b1, 1'b0);
        check("frames_100", bus.user_data_out, 32'hC064_0001);
        for (int i = 101; i < 16383; i++) cyc(1'b1, 1'b1, 1'b0);
        check("frames_16382", bus.user_data_out, 32'hFFFE_0001);
        cyc(1'b1, 1'b1, 1'b0);
        check("frames_16383", bus.user_data_out, 32'hFFFF_0001);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
        check("frames_hold", bus.user_data_out, 32'hFFFF_0001);

        // Peak saturation: one long frame of continuous overflow.
        for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b1, 1'b0);
        check("peak_pending", bus.user_data_out, 32'hFFFF_0001);
        cyc(1'b1, 1'b0, 1'b0);
        check("peak_sat", bus.user_data_out, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 1'b0);
        check("peak_hold", bus.user_data_out, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
